bp_fpga_host_io_arbiter: RTL and testbench

// - Shares the single BedRock IO command/response port of bp_fpga_host among num_req_p requesters.
// - Requesters include the core IO path, a loopback/test sender and a debug injector.
// - Round-robin arbitration on commands.
// - Each granted requester ID is recorded in an in-order tag FIFO, so host responses route back to the issuer.
// - Sits between the requesters and the fpga_host io_cmd_i/io_resp_o ports.
//

---
 rtl/bp_fpga_host_io_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_bp_fpga_host_io_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fpga_host_io_arbiter.sv
// bp_fpga_host_io_arbiter
//
// Lets num_req_p requesters share the single BedRock IO command/response
// port of bp_fpga_host. These requesters are the core IO path, a loopback
// sender and a debug injector.
//
// Commands are arbitrated round-robin and passed straight through with no
// added latency. For each accepted command, the grantee's ID is pushed into
// an in-order tag FIFO. The head of that FIFO steers the next host response
// back to the requester that issued it.
//
// Ports
//   clk_i                 clock
//   reset_i               synchronous active-high reset
//   req_cmd_i             requester commands, requester i in [i*msg_width_p +: msg_width_p]
//   req_cmd_v_i           per-requester command valid
//   req_cmd_ready_and_o   per-requester command accept (ready&valid)
//   req_resp_o            host response, broadcast to all requesters
//   req_resp_v_o          response valid, one-hot to the owning requester
//   req_resp_yumi_i       per-requester response consume
//   host_cmd_o            command to fpga_host io_cmd_i
//   host_cmd_v_o          command valid to fpga_host
//   host_cmd_ready_and_i  fpga_host command ready
//   host_resp_i           response from fpga_host io_resp_o
//   host_resp_v_i         response valid from fpga_host
//   host_resp_yumi_o      response consume to fpga_host
//   outstanding_o         number of commands awaiting a response
//   error_o               sticky flag: a response arrived with nothing outstanding
module bp_fpga_host_io_arbiter #(
    parameter int num_req_p      = 2,
    parameter int msg_width_p    = 128,
    parameter int max_outstand_p = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_req_p*msg_width_p-1:0]      req_cmd_i,
    input  logic [num_req_p-1:0]                  req_cmd_v_i,
    output logic [num_req_p-1:0]                  req_cmd_ready_and_o,
    output logic [msg_width_p-1:0]                req_resp_o,
    output logic [num_req_p-1:0]                  req_resp_v_o,
    input  logic [num_req_p-1:0]                  req_resp_yumi_i,
    output logic [msg_width_p-1:0]                host_cmd_o,
    output logic                                  host_cmd_v_o,
    input  logic                                  host_cmd_ready_and_i,
    input  logic [msg_width_p-1:0]                host_resp_i,
    input  logic                                  host_resp_v_i,
    output logic                                  host_resp_yumi_o,
    output logic [$clog2(max_outstand_p+1)-1:0]   outstanding_o,
    output logic                                  error_o
);

    localparam int tag_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int addr_w_lp = (max_outstand_p > 1) ? $clog2(max_outstand_p) : 1;
    localparam int cnt_w_lp  = $clog2(max_outstand_p + 1);

    logic                 reset_hold_r;
    logic [tag_w_lp-1:0]  ptr_r;
    logic [tag_w_lp-1:0]  tag_mem [max_outstand_p];
    logic [addr_w_lp-1:0] wr_ptr_r;
    logic [addr_w_lp-1:0] rd_ptr_r;
    logic [cnt_w_lp-1:0]  count_r;
    logic                 error_r;

    logic                 blocked;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [tag_w_lp-1:0]  grant_idx;
    logic                 grant_found;
    logic                 fire;
    logic                 pop;
    logic                 unsolicited;
    logic [tag_w_lp-1:0]  head_tag;
    logic [tag_w_lp-1:0]  ptr_next;
    logic [addr_w_lp-1:0] wr_ptr_next;
    logic [addr_w_lp-1:0] rd_ptr_next;

    // All handshake outputs stay low during reset and for one cycle after
    // it. This gives the host side a clean cycle to come out of its own
    // reset.
    always_ff @(posedge clk_i) begin
        reset_hold_r <= reset_i;
    end

    assign blocked    = reset_i | reset_hold_r;
    assign fifo_full  = (count_r == cnt_w_lp'(max_outstand_p));
    assign fifo_empty = (count_r == '0);
    assign head_tag   = tag_mem[rd_ptr_r];

    // Round-robin search: the first valid requester at or above ptr_r,
    // wrapping modulo num_req_p.
    always_comb begin
        int                  idx;
        logic [tag_w_lp-1:0] idx_t;
        idx         = 0;
        idx_t       = '0;
        grant_idx   = ptr_r;
        grant_found = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            idx_t = tag_w_lp'(idx);
            if (!grant_found && req_cmd_v_i[idx_t]) begin
                grant_found = 1'b1;
                grant_idx   = idx_t;
            end
        end
    end

    // Valid is never qualified by host ready. A full tag FIFO blocks
    // grants even when a pop happens in the same cycle.
    assign host_cmd_v_o = ~blocked & grant_found & ~fifo_full;
    assign host_cmd_o   = req_cmd_i[grant_idx*msg_width_p +: msg_width_p];
    assign fire         = host_cmd_v_o & host_cmd_ready_and_i;

    always_comb begin
        req_cmd_ready_and_o = '0;
        if (fire) begin
            req_cmd_ready_and_o[grant_idx] = 1'b1;
        end
    end

    // Route responses to the FIFO head. A yumi only counts when it comes
    // from the head owner. With nothing outstanding, any response is
    // drained and flagged as an error.
    always_comb begin
        req_resp_v_o     = '0;
        host_resp_yumi_o = 1'b0;
        pop              = 1'b0;
        unsolicited      = 1'b0;
        if (!blocked) begin
            if (!fifo_empty) begin
                req_resp_v_o[head_tag] = host_resp_v_i;
                host_resp_yumi_o       = req_resp_yumi_i[head_tag];
                pop                    = req_resp_yumi_i[head_tag];
            end else begin
                host_resp_yumi_o = host_resp_v_i;
                unsolicited      = host_resp_v_i;
            end
        end
    end

    assign req_resp_o = host_resp_i;

    assign ptr_next    = (grant_idx == tag_w_lp'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;
    assign wr_ptr_next = (wr_ptr_r == addr_w_lp'(max_outstand_p - 1)) ? '0 : wr_ptr_r + 1'b1;
    assign rd_ptr_next = (rd_ptr_r == addr_w_lp'(max_outstand_p - 1)) ? '0 : rd_ptr_r + 1'b1;

    // Tag storage needs no reset because occupancy is tracked separately.
    always_ff @(posedge clk_i) begin
        if (fire) begin
            tag_mem[wr_ptr_r] <= grant_idx;
        end
    end

    // Priority pointer, FIFO pointers, occupancy and the sticky error
    // flag. Reset discards any tags still in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            error_r  <= 1'b0;
        end else begin
            if (fire) begin
                ptr_r    <= ptr_next;
                wr_ptr_r <= wr_ptr_next;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_next;
            end
            case ({fire, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (unsolicited) begin
                error_r <= 1'b1;
            end
        end
    end

    assign outstanding_o = count_r;
    assign error_o       = error_r;

endmodule

// File: tb/tb_bp_fpga_host_io_arbiter.sv
// Testbench for bp_fpga_host_io_arbiter.
//
// Each step drives one cycle of inputs at the falling edge. The bench then
// compares every output against a queue-based model of the arbiter and
// advances the model at the rising edge.
module tb_bp_fpga_host_io_arbiter;

    localparam int N  = 2;
    localparam int W  = 128;
    localparam int M  = 4;
    localparam int CW = 3;
    localparam int TW = 1;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [N*W-1:0] req_cmd_i;
    logic [N-1:0]   req_cmd_v_i;
    logic [N-1:0]   req_cmd_ready_and_o;
    logic [W-1:0]   req_resp_o;
    logic [N-1:0]   req_resp_v_o;
    logic [N-1:0]   req_resp_yumi_i;
    logic [W-1:0]   host_cmd_o;
    logic           host_cmd_v_o;
    logic           host_cmd_ready_and_i;
    logic [W-1:0]   host_resp_i;
    logic           host_resp_v_i;
    logic           host_resp_yumi_o;
    logic [CW-1:0]  outstanding_o;
    logic           error_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the in-order tag list, the next-priority
    // requester, the sticky error flag, and whether reset was high at the
    // last edge.
    int q[$];
    int m_ptr = 0;
    bit m_err = 1'b0;
    bit m_rstd = 1'b1;
    int cnt_grant[N];

    bp_fpga_host_io_arbiter #(
        .num_req_p(N), .msg_width_p(W), .max_outstand_p(M)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .req_cmd_i(req_cmd_i),
        .req_cmd_v_i(req_cmd_v_i),
        .req_cmd_ready_and_o(req_cmd_ready_and_o),
        .req_resp_o(req_resp_o),
        .req_resp_v_o(req_resp_v_o),
        .req_resp_yumi_i(req_resp_yumi_i),
        .host_cmd_o(host_cmd_o),
        .host_cmd_v_o(host_cmd_v_o),
        .host_cmd_ready_and_i(host_cmd_ready_and_i),
        .host_resp_i(host_resp_i),
        .host_resp_v_i(host_resp_v_i),
        .host_resp_yumi_o(host_resp_yumi_o),
        .outstanding_o(outstanding_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    // A hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task applyStimulus(input logic rst, input logic [N-1:0] cv, input logic rdy,
                       input logic rv, input logic [N-1:0] ym);
        bit           blk;
        bit           full;
        bit           expv;
        bit           pop;
        bit           unsol;
        int           g;
        int           bestd;
        int           d;
        logic [TW-1:0] gi;
        logic [TW-1:0] hi;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic         exp_ym;

        reset_i              = rst;
        req_cmd_v_i          = cv;
        host_cmd_ready_and_i = rdy;
        host_resp_v_i        = rv;
        req_resp_yumi_i      = ym;
        for (int i = 0; i < N*W/32; i++) req_cmd_i[i*32 +: 32] = $urandom();
        for (int i = 0; i < W/32; i++) host_resp_i[i*32 +: 32] = $urandom();
        #2;

        // The grantee is the valid requester closest to m_ptr, counting
        // upward with wrap.
        blk   = rst || m_rstd;
        full  = (q.size() == M);
        g     = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - m_ptr + N) % N;
            if (cv[i] && d < bestd) begin
                bestd = d;
                g     = i;
            end
        end
        gi      = TW'(g);
        expv    = !blk && (g >= 0) && !full;
        exp_rdy = '0;
        if (expv && rdy) exp_rdy[gi] = 1'b1;

        exp_rv = '0;
        exp_ym = 1'b0;
        pop    = 1'b0;
        unsol  = 1'b0;
        if (!blk) begin
            if (q.size() > 0) begin
                hi = TW'(q[0]);
                if (rv) exp_rv[hi] = 1'b1;
                exp_ym = ym[hi];
                pop    = ym[hi];
            end else begin
                exp_ym = rv;
                unsol  = rv;
            end
        end

        checkOutput("host_cmd_v", W'(host_cmd_v_o), W'(expv));
        checkOutput("cmd_ready", W'(req_cmd_ready_and_o), W'(exp_rdy));
        checkOutput("resp_v", W'(req_resp_v_o), W'(exp_rv));
        checkOutput("host_yumi", W'(host_resp_yumi_o), W'(exp_ym));
        checkOutput("resp_data", req_resp_o, host_resp_i);
        checkOutput("outstanding", W'(outstanding_o), W'(q.size()));
        checkOutput("error", W'(error_o), W'(m_err));
        if (expv) checkOutput("host_cmd_data", host_cmd_o, req_cmd_i[g*W +: W]);

        for (int i = 0; i < N; i++) if (req_cmd_ready_and_o[i] === 1'b1) cnt_grant[i]++;

        @(posedge clk_i);
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_err = 1'b0;
        end else begin
            if (expv && rdy) begin
                q.push_back(g);
                m_ptr = (g + 1) % N;
            end
            if (pop) void'(q.pop_front());
            if (unsol) m_err = 1'b1;
        end
        m_rstd = rst;
        @(negedge clk_i);
    endtask

    task drainAll();
        for (int i = 0; i < M + 1; i++) begin
            if (q.size() > 0) applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 2'b11);
        end
    endtask

    initial begin
        reset_i              = 1'b1;
        req_cmd_i            = '0;
        req_cmd_v_i          = '0;
        host_cmd_ready_and_i = 1'b0;
        host_resp_i          = '0;
        host_resp_v_i        = 1'b0;
        req_resp_yumi_i      = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        $display("[TB] reset, with every input active");
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 2'b11);
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 2'b11);

        $display("[TB] single request from req1");
        applyStimulus(1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
        repeat (4) applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 2'b10);
        checkOutput("single_done", W'(outstanding_o), W'(0));

        $display("[TB] fairness");
        cnt_grant[0] = 0;
        cnt_grant[1] = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'b11, 1'b1, q.size() > 0, 2'b11);
        checkOutput("fair_cnt0", W'(cnt_grant[0]), W'(4));
        checkOutput("fair_cnt1", W'(cnt_grant[1]), W'(4));
        drainAll();

        $display("[TB] backpressure");
        repeat (10) applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 2'b00);
        drainAll();

        $display("[TB] full tag FIFO");
        repeat (4) applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b1, 2'b01);
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 2'b00);
        drainAll();

        $display("[TB] response ordering");
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2'b10);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2'b10);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2'b10);

        $display("[TB] unsolicited response");
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
        repeat (3) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        checkOutput("err_sticky", W'(error_o), W'(1));
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), N'($urandom()),
                          1'($urandom()), 1'($urandom()), N'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
